// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder slice.
//   state_t  : responder FSM states (IDLE, WAIT, RESP)
//   kind_t   : decoded request kind (LOAD, STORE, NOP, BAD)
//   LAT_W    : width of the latency down-counter
//   decode_kind(): maps the mem_read/mem_write pair onto kind_t
package dmem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    LOAD,
    STORE,
    NOP,
    BAD
  } kind_t;

  // Both strobes set at once is a malformed request from the core.
  function automatic kind_t decode_kind(input logic rd, input logic wr);
    kind_t k;
    case ({rd, wr})
      2'b10:   k = LOAD;
      2'b01:   k = STORE;
      2'b00:   k = NOP;
      default: k = BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the core sequencer
// and the data-memory responder.
//   req_valid/req_ready : request handshake (core -> memory)
//   mem_read/mem_write  : request kind strobes
//   addr, wdata         : 64-bit byte address and store data
//   rsp_valid           : one-cycle response strobe (memory -> core)
//   rdata, rsp_err      : load data and fault flag, qualified by rsp_valid
// Modports: master = core side, slave = responder side.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        rsp_valid;
  logic [63:0] rdata;
  logic        rsp_err;

  modport master (
    output req_valid, mem_read, mem_write, addr, wdata,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, wdata,
    output req_ready, rsp_valid, rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit data-memory storage.
//   clk          : write clock
//   we           : write enable, sampled on the rising edge
//   waddr, wdata : write word index and data
//   raddr        : read word index
//   rdata        : combinational read data
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's ld/sd requests.
// Accepts one doubleword load/store per handshake, waits LATENCY cycles,
// then returns a single-cycle response (load data or store ack) with an
// error flag for out-of-range or malformed requests.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : dmem_responder_if.slave request/response bus
// Parameters: DEPTH (words, power of two 2..65536), LATENCY (1..15).
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, a byte address
// not aligned to 8 faults; otherwise the low three bits are ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_responder_if.slave     bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  kind_t              kind_q, kind_d;
  logic               err_q, err_d;
  logic [63:0]        data_q, data_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [63:0]        word_addr;
  logic [AW-1:0]      idx;
  logic               range_err;
  logic               align_err;
  logic               acc_err;
  kind_t              acc_kind;
  logic               accept;
  logic               we;
  logic [63:0]        arr_rdata;

  // Shifting the whole address keeps every address bit in play: anything
  // left above the index bits means the address is past the array.
  assign word_addr = bus.addr >> 3;
  assign idx       = word_addr[AW-1:0];
  assign range_err = |word_addr[63:AW];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = |bus.addr[2:0];
`else
  assign align_err = 1'b0;
`endif

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign acc_kind = decode_kind(bus.mem_read, bus.mem_write);

  // A no-op never touches the array, so address faults only apply to
  // real loads and stores; a malformed strobe pair always faults.
  always_comb begin
    acc_err = 1'b0;
    case (acc_kind)
      LOAD, STORE: acc_err = range_err || align_err;
      BAD:         acc_err = 1'b1;
      default:     acc_err = 1'b0;
    endcase
  end

  // Stores commit at the acceptance edge, so a later reset cannot undo them.
  assign we = accept && (acc_kind == STORE) && !acc_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (idx),
    .wdata (bus.wdata),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  // Next-state, latch and output-register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    err_d     = err_q;
    data_d    = data_q;
    rdata_d   = '0;
    rsp_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          kind_d  = acc_kind;
          err_d   = acc_err;
          data_d  = arr_rdata;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers are loaded only for the RESP cycle and cleared
    // everywhere else, so rdata/rsp_err read as 0 outside a response.
    if (state_d == RESP) begin
      rsp_err_d = err_d;
      if ((kind_d == LOAD) && !err_d) begin
        rdata_d = data_d;
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kind_q    <= NOP;
      err_q     <= 1'b0;
      data_q    <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      err_q     <= err_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rdata     = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
